// File: rtl/top_multiplier.sv
// Sequential shift-add unsigned 8x8 multiplier with a three-state FSM.
// Launch at edge N (start in IDLE) -> final product on pp after edge N+8.
// No handshake: start is a level request, held start in DONE does not retrigger.
module top_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_A,
  input  logic [7:0]  in_B,
  output logic [15:0] pp
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] A_r;
  logic [7:0]  B_r;
  logic [3:0]  cnt;

  // State register; reset overrides any transition, aborting a multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed 8-cycle RUN, DONE waits for start to drop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 4'd7) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operands captured at launch, one shift-add step per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      A_r <= 16'h0000;
      B_r <= 8'h00;
      cnt <= 4'd0;
      pp  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            A_r <= {8'h00, in_A};
            B_r <= in_B;
            cnt <= 4'd0;
            pp  <= 16'h0000;
          end
        end
        RUN: begin
          // Max product is 0xFE01, so the 16-bit sum cannot wrap.
          if (B_r[0]) pp <= pp + A_r;
          A_r <= A_r << 1;
          B_r <= B_r >> 1;
          cnt <= cnt + 4'd1;
        end
        default: begin
          // DONE (and any illegal code) holds every register.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_multiplier.sv
module tb_top_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_A;
  logic [7:0]  in_B;
  logic [15:0] pp;

  top_multiplier dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in_A  (in_A),
    .in_B  (in_B),
    .pp    (pp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: compares pp against the scoreboard entry due at this edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.due < cyc) begin
        failures++;
        $display("FAIL %s: check at edge %0d missed (now edge %0d)", e.name, e.due, cyc);
      end else if (pp !== e.exp) begin
        failures++;
        $display("FAIL %s: edge %0d pp=0x%04h expected 0x%04h", e.name, cyc, pp, e.exp);
      end
    end
  end

  function automatic void expect_at(input int due, input logic [15:0] v, input string name);
    exp_t e;
    e.due = due;
    e.exp = v;
    e.name = name;
    exp_q.push_back(e);
  endfunction

  // One multiply: launch, scramble inputs during RUN, then check pp for hold+1 edges.
  // keep=1 holds start high throughout (must not retrigger); afterwards one start=0 edge.
  task automatic mul(input logic [7:0] a, input logic [7:0] b, input bit keep,
                     input int hold, input string name);
    int          e;
    logic [15:0] prod;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    in_A  = a;
    in_B  = b;
    e     = cyc + 1;
    prod  = 16'(int'(a) * int'(b));
    for (int i = 0; i <= hold; i++) expect_at(e + 8 + i, prod, name);
    for (int i = 0; i < 8 + hold; i++) begin
      @(negedge clk);
      if (!keep) start = 1'b0;
      in_A = 8'($urandom);
      in_B = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int e;
    reset = 1'b1;
    start = 1'b0;
    in_A  = 8'h00;
    in_B  = 8'h00;
    expect_at(1, 16'h0000, "reset_pp_0");
    expect_at(2, 16'h0000, "reset_pp_1");
    @(negedge clk);

    // Release reset and launch on the same edge; start held high through DONE.
    mul(8'hD7, 8'h93, 1'b1, 4, "s1_d7x93_held");

    // Corner operands, start pulsed.
    mul(8'hFF, 8'hFF, 1'b0, 1, "s2_ffxff");
    mul(8'h00, 8'hAB, 1'b0, 0, "s2_00xab");
    mul(8'h01, 8'h80, 1'b0, 0, "s2_01x80");

    // Reset during the 4th RUN cycle discards the partial product.
    @(negedge clk);
    start = 1'b1;
    in_A  = 8'hD7;
    in_B  = 8'h93;
    e     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expect_at(e + 4, 16'h0000, "s3_abort_reset");
    expect_at(e + 5, 16'h0000, "s3_abort_idle");
    @(negedge clk);
    reset = 1'b0;
    mul(8'h5A, 8'h03, 1'b0, 0, "s3_after_abort");

    // Inputs changing during RUN are ignored (mul scrambles them).
    mul(8'hD7, 8'h93, 1'b0, 0, "s4_d7x93_ignore");

    // Back-to-back with one start=0 cycle between.
    mul(8'h0F, 8'h11, 1'b1, 0, "s5_0fx11");
    mul(8'h80, 8'h02, 1'b1, 0, "s5_80x02");

    // Random pairs against the arithmetic product.
    for (int i = 0; i < 1000; i++) begin
      mul(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
          $urandom_range(0, 1), "random");
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      checks++;
      $display("FAIL drain: %0d checks still pending, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
